depth_image_write: RTL and testbench
====================================

Name: depth_image_write

Overview:
- Sink-side companion to the image reader/disparity stage; receives the HSYNC-qualified stream of two 8-bit pixels per cycle.
- Reassembles each frame into an internal WIDTH*HEIGHT frame buffer, tracks row and column, and flags frame completion.
- Detects protocol errors: short lines and unexpected data.
- A registered read-back port exposes the stored frame to the bench or a downstream file-dump stage.

Parameters:
- WIDTH, 320, image width in pixels; must be even.
- HEIGHT, 240, image height in lines.
- DW, 8, pixel data width.

Ports:
- HCLK  input  1  clock; all state updates on the rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- VSYNC  input  1  frame-start indication; a rising edge starts a new frame.
- HSYNC  input  1  data-valid; high means DATA_0/DATA_1 carry a pixel pair this cycle.
- DATA_0  input  DW  even pixel (column col).
- DATA_1  input  DW  odd pixel (column col+1).
- rd_addr  input  17  read-back pixel address, row*WIDTH+col.
- rd_data  output  DW  read-back pixel, registered.
- row_cnt  output  10  index of the line currently being filled.
- frame_done  output  1  high from completion of the last pixel pair until the next VSYNC rise.
- busy  output  1  high while in ST_FRAME.
- err_short_line  output  1  sticky: HSYNC dropped mid-line.
- err_unexpected  output  1  sticky: HSYNC high outside ST_FRAME.

Behaviour:
- Reset (HRESETn low, asynchronous):
  - State goes to ST_IDLE.
  - col, row_cnt, frame_done, busy, both error flags and rd_data go to 0.
  - The VSYNC edge register goes to 0.
  - Frame-buffer contents are not cleared.
  - Reset mid-frame abandons the frame; the partly written buffer is retained.
- VSYNC edge detect:
  - vs_d <= VSYNC each cycle; vs_rise = VSYNC & ~vs_d.
  - VSYNC held high for many cycles yields exactly one vs_rise.
- States and transitions:
  - ST_IDLE: vs_rise -> ST_FRAME.
  - ST_FRAME: last pair written -> ST_DONE.
  - ST_DONE: vs_rise -> ST_FRAME.
  - vs_rise in any state: col<=0, row_cnt<=0, frame_done<=0, both error flags<=0, next state ST_FRAME.
  - vs_rise has priority over HSYNC in the same cycle; that cycle's data is dropped and no error is flagged.
- ST_FRAME data path:
  - With HSYNC=1: mem[row_cnt*WIDTH+col]<=DATA_0 and mem[row_cnt*WIDTH+col+1]<=DATA_1 in the same edge (zero-latency write).
  - If col==WIDTH-2: col<=0 and row_cnt<=row_cnt+1; otherwise col<=col+2.
  - If row_cnt==HEIGHT-1 and col==WIDTH-2: the last pair is written; next state ST_DONE, frame_done=1 and busy=0 from the following cycle, row_cnt stays HEIGHT-1 (no wrap to HEIGHT).
  - Total beats per frame = WIDTH*HEIGHT/2 (38400 at defaults).
- Short line:
  - In ST_FRAME, HSYNC=0 with col!=0 sets err_short_line.
  - col<=0, row_cnt unchanged; the next HSYNC burst overwrites the same line from column 0.
  - HSYNC=0 with col==0 is a normal inter-line gap, unlimited length.
- Unexpected data:
  - HSYNC=1 in ST_IDLE or ST_DONE (without vs_rise) sets err_unexpected.
  - No memory write occurs.
- Read-back:
  - rd_data <= mem[rd_addr] every cycle, giving 1-cycle latency.
  - rd_addr >= WIDTH*HEIGHT returns 0.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
- Address arithmetic:
  - row_cnt*WIDTH+col computed at 17 bits; no overflow at the defaults.
- busy = (state==ST_FRAME), registered.

Test Plan:
1. Reset, VSYNC pulse, then 240 lines of 160 HSYNC beats with DATA_0=(2k)&255, DATA_1=(2k+1)&255, 160-cycle gaps between lines -> frame_done rises exactly one cycle after the 38400th beat; row_cnt=239. Reading all 76800 addresses returns addr&255, each one cycle after the address is applied. Both error flags stay 0.
2. HSYNC drop after 50 beats on line 3, then a full 160-beat line 3 -> err_short_line=1, row_cnt stays 3 until the full line completes. The line-3 contents equal the second burst; the frame still completes at 38400 valid beats excluding the aborted 50.
3. After frame_done, drive 4 more HSYNC beats with data 0xAA -> err_unexpected=1; buffer contents are unchanged; frame_done stays 1.
4. Same-cycle VSYNC rise and HSYNC=1 in ST_DONE -> state ST_FRAME, frame_done=0, err flags cleared, no write, col=0.
5. Assert HRESETn low at beat 1000 mid-frame -> all outputs 0 asynchronously (before the next clock edge). After release, HSYNC without VSYNC sets err_unexpected; a subsequent VSYNC plus full frame completes normally.
6. Read-back at rd_addr=76800 and 131071 -> rd_data=0. A read of address 5 concurrent with its write returns the previous value, and the new value on the following read.

Source files
------------

// File: rtl/depth_image_write_if.sv
// Pixel-pair stream from the disparity stage: VSYNC frame start, HSYNC-qualified
// even/odd pixel pair per cycle.
interface depth_image_write_if #(
    parameter int DW = 8
);
    logic          VSYNC;
    logic          HSYNC;
    logic [DW-1:0] DATA_0;
    logic [DW-1:0] DATA_1;

    modport master (output VSYNC, output HSYNC, output DATA_0, output DATA_1);
    modport slave  (input  VSYNC, input  HSYNC, input  DATA_0, input  DATA_1);
endinterface

// File: rtl/depth_image_write.sv
// Frame sink: reassembles the HSYNC pixel-pair stream into a WIDTH*HEIGHT buffer,
// tracks position, flags completion and protocol errors, and offers a registered read-back.
module depth_image_write #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DW     = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    depth_image_write_if.slave  s_if,
    input  logic [16:0]         rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic [9:0]          row_cnt,
    output logic                frame_done,
    output logic                busy,
    output logic                err_short_line,
    output logic                err_unexpected
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int PAIRS = TOTAL / 2;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int CW    = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [9:0]      row_q, row_d;
    logic            vs_q, vs_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;
    logic            err_short_q, err_short_d;
    logic            err_unexp_q, err_unexp_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    logic            vs_rise;
    logic            wr_en;
    logic [16:0]     wr_addr;
    logic [PW-1:0]   wr_idx;
    logic            rd_in_range;
    logic [PW-1:0]   rd_idx;
    logic [2*DW-1:0] rd_word;

    // Each entry holds one even/odd pair: {odd, even}, so a beat is a single write.
    logic [2*DW-1:0] mem [PAIRS];

    assign vs_d    = s_if.VSYNC;
    assign vs_rise = s_if.VSYNC & ~vs_q;
    assign wr_addr = 17'(row_q) * 17'(WIDTH) + 17'(col_q);
    assign wr_idx  = PW'(wr_addr >> 1);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        err_short_d = err_short_q;
        err_unexp_d = err_unexp_q;
        wr_en       = 1'b0;

        if (vs_rise) begin
            // Frame start wins over any data presented in the same cycle.
            state_d     = ST_FRAME;
            col_d       = '0;
            row_d       = '0;
            err_short_d = 1'b0;
            err_unexp_d = 1'b0;
        end else begin
            case (state_q)
                ST_FRAME: begin
                    if (s_if.HSYNC) begin
                        wr_en = 1'b1;
                        if (col_q == CW'(WIDTH - 2)) begin
                            col_d = '0;
                            if (row_q == 10'(HEIGHT - 1)) state_d = ST_DONE;
                            else                          row_d   = row_q + 10'd1;
                        end else begin
                            col_d = col_q + CW'(2);
                        end
                    end else if (col_q != '0) begin
                        // Line aborted: restart it from column 0, same row.
                        err_short_d = 1'b1;
                        col_d       = '0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (s_if.HSYNC) err_unexp_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d       = (state_d == ST_FRAME);
        frame_done_d = (state_d == ST_DONE);
    end

    assign rd_in_range = (rd_addr < 17'(TOTAL));
    assign rd_idx      = rd_in_range ? PW'(rd_addr >> 1) : '0;
    assign rd_word     = mem[rd_idx];

    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) rd_data_d = rd_addr[0] ? rd_word[2*DW-1:DW] : rd_word[DW-1:0];
    end

    // NOTE: the frame buffer has no reset; clearing a RAM is neither needed nor mappable.
    always_ff @(posedge HCLK) begin
        if (wr_en) mem[wr_idx] <= {s_if.DATA_1, s_if.DATA_0};
    end

    // NOTE: state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            vs_q         <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_short_q  <= 1'b0;
            err_unexp_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vs_q         <= vs_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_short_q  <= err_short_d;
            err_unexp_q  <= err_unexp_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data        = rd_data_q;
    assign row_cnt        = row_q;
    assign frame_done     = frame_done_q;
    assign busy           = busy_q;
    assign err_short_line = err_short_q;
    assign err_unexpected = err_unexp_q;

endmodule

// File: tb/tb_depth_image_write.sv
// Directed bench for depth_image_write on a reduced 16x6 frame: full frames, short
// line, unexpected data, VSYNC/HSYNC collision, mid-frame reset, read-back corners.
module tb_depth_image_write;

    localparam int W     = 16;
    localparam int H     = 6;
    localparam int DW    = 8;
    localparam int TOTAL = W * H;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [16:0]   rd_addr;
    logic [DW-1:0] rd_data;
    logic [9:0]    row_cnt;
    logic          frame_done;
    logic          busy;
    logic          err_short_line;
    logic          err_unexpected;

    depth_image_write_if #(.DW(DW)) s_if ();

    depth_image_write #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .s_if           (s_if),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .row_cnt        (row_cnt),
        .frame_done     (frame_done),
        .busy           (busy),
        .err_short_line (err_short_line),
        .err_unexpected (err_unexpected)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  exp;
    } rd_vec_t;

    rd_vec_t vec_a [6];
    rd_vec_t vec_b [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int a);
        case (mode)
            0:       return 8'(a);
            1:       return 8'(a + 64);
            default: return 8'(a ^ 255);
        endcase
    endfunction

    task automatic beat(input logic [7:0] d0, input logic [7:0] d1);
        s_if.HSYNC  = 1'b1;
        s_if.DATA_0 = d0;
        s_if.DATA_1 = d1;
        step();
        s_if.HSYNC  = 1'b0;
    endtask

    task automatic send_line(input int row, input int first_beat, input int nbeats, input int mode);
        for (int b = first_beat; b < first_beat + nbeats; b++) begin
            int a;
            a = row * W + 2 * b;
            beat(pix(mode, a), pix(mode, a + 1));
        end
    endtask

    task automatic vs_pulse();
        s_if.VSYNC = 1'b1;
        step();
        s_if.VSYNC = 1'b0;
        step();
    endtask

    task automatic read_check(input string name, input int addr, input logic [7:0] exp);
        rd_addr = 17'(addr);
        step();
        check(name, rd_data, exp);
    endtask

    // Rows first_row..H-1, watching the completion edge on the final pair.
    task automatic frame_rows(input int mode, input int first_row);
        for (int r = first_row; r < H; r++) begin
            if (r < H - 1) begin
                send_line(r, 0, W / 2, mode);
                repeat (3) step();
            end else begin
                send_line(r, 0, W / 2 - 1, mode);
                check("pre_last_done", frame_done, 1'b0);
                check("pre_last_busy", busy, 1'b1);
                check("pre_last_row", row_cnt, H - 1);
                send_line(r, W / 2 - 1, 1, mode);
                check("last_done", frame_done, 1'b1);
                check("last_busy", busy, 1'b0);
                check("last_row", row_cnt, H - 1);
            end
        end
    endtask

    task automatic read_all(input string name, input int mode);
        for (int a = 0; a < TOTAL; a++) read_check(name, a, pix(mode, a));
    endtask

    initial begin
        vec_a[0] = '{17'd0,      8'd0};
        vec_a[1] = '{17'd1,      8'd1};
        vec_a[2] = '{17'd16,     8'd16};
        vec_a[3] = '{17'd95,     8'd95};
        vec_a[4] = '{17'd96,     8'd0};
        vec_a[5] = '{17'd131071, 8'd0};

        vec_b[0] = '{17'd0,  8'd64};
        vec_b[1] = '{17'd1,  8'd65};
        vec_b[2] = '{17'd80, 8'd144};
        vec_b[3] = '{17'd81, 8'd145};
        vec_b[4] = '{17'd95, 8'd159};

        HRESETn     = 1'b0;
        s_if.VSYNC  = 1'b0;
        s_if.HSYNC  = 1'b0;
        s_if.DATA_0 = '0;
        s_if.DATA_1 = '0;
        rd_addr     = '0;

        // Reset state
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_row", row_cnt, 0);
        check("rst_done", frame_done, 1'b0);
        check("rst_err_short", err_short_line, 1'b0);
        check("rst_err_unexp", err_unexpected, 1'b0);
        check("rst_rd_data", rd_data, 0);
        HRESETn = 1'b1;
        step();

        // 1: clean frame, pixel = addr & 255
        vs_pulse();
        check("t1_busy", busy, 1'b1);
        frame_rows(0, 0);
        check("t1_err_short", err_short_line, 1'b0);
        check("t1_err_unexp", err_unexpected, 1'b0);
        read_all("t1_rd_all", 0);
        for (int i = 0; i < 6; i++)
            read_check($sformatf("t1_vec%0d", i), int'(vec_a[i].addr), vec_a[i].exp);

        // 2: short line on row 3 after 3 beats, then a full row 3
        vs_pulse();
        for (int r = 0; r < 3; r++) begin
            send_line(r, 0, W / 2, 1);
            repeat (3) step();
        end
        for (int b = 0; b < 3; b++) beat(8'hEE, 8'hEE);
        step();
        check("t2_err_short", err_short_line, 1'b1);
        check("t2_row_after_drop", row_cnt, 3);
        repeat (2) step();
        send_line(3, 0, W / 2 - 1, 1);
        check("t2_row_mid", row_cnt, 3);
        send_line(3, W / 2 - 1, 1, 1);
        check("t2_row_next", row_cnt, 4);
        repeat (3) step();
        frame_rows(1, 4);
        check("t2_err_short_sticky", err_short_line, 1'b1);
        check("t2_err_unexp", err_unexpected, 1'b0);
        read_all("t2_rd_all", 1);

        // 3: data after frame_done
        for (int b = 0; b < 4; b++) beat(8'hAA, 8'hAA);
        check("t3_err_unexp", err_unexpected, 1'b1);
        check("t3_done", frame_done, 1'b1);
        check("t3_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++)
            read_check($sformatf("t3_vec%0d", i), int'(vec_b[i].addr), vec_b[i].exp);

        // 4: VSYNC rise with HSYNC in ST_DONE; VSYNC then held high
        s_if.VSYNC  = 1'b1;
        s_if.HSYNC  = 1'b1;
        s_if.DATA_0 = 8'h55;
        s_if.DATA_1 = 8'h55;
        step();
        s_if.HSYNC  = 1'b0;
        check("t4_busy", busy, 1'b1);
        check("t4_done", frame_done, 1'b0);
        check("t4_err_short", err_short_line, 1'b0);
        check("t4_err_unexp", err_unexpected, 1'b0);
        check("t4_row", row_cnt, 0);
        read_check("t4_no_write0", 0, 8'd64);
        read_check("t4_no_write1", 1, 8'd65);
        beat(8'h11, 8'h22);
        send_line(0, 1, W / 2 - 1, 2);
        send_line(1, 0, W / 2, 2);
        s_if.VSYNC = 1'b0;
        check("t4_busy_hold", busy, 1'b1);
        check("t4_row_hold", row_cnt, 2);
        read_check("t4_col0_even", 0, 8'h11);
        read_check("t4_col0_odd", 1, 8'h22);
        read_check("t4_row1", 16, 8'd239);
        check("t4_no_err", err_short_line, 1'b0);

        // 5: asynchronous reset mid-frame
        rd_addr = 17'd0;
        send_line(2, 0, 3, 2);
        check("t5_pre_busy", busy, 1'b1);
        check("t5_pre_rd", rd_data, 8'h11);
        #2;
        HRESETn = 1'b0;
        #1;
        check("t5_async_busy", busy, 1'b0);
        check("t5_async_row", row_cnt, 0);
        check("t5_async_done", frame_done, 1'b0);
        check("t5_async_err_short", err_short_line, 1'b0);
        check("t5_async_err_unexp", err_unexpected, 1'b0);
        check("t5_async_rd", rd_data, 0);
        #1;
        HRESETn = 1'b1;
        step();
        check("t5_retained", rd_data, 8'h11);
        beat(8'h99, 8'h99);
        check("t5_err_unexp", err_unexpected, 1'b1);
        check("t5_idle_busy", busy, 1'b0);
        read_check("t5_no_write", 0, 8'h11);
        read_check("t5_partial_kept", 34, 8'd221);
        vs_pulse();
        check("t5_err_cleared", err_unexpected, 1'b0);
        frame_rows(0, 0);
        check("t5_err_short", err_short_line, 1'b0);
        read_all("t5_rd_all", 0);

        // 6: out-of-range read-back and read-before-write
        read_check("t6_oob_total", TOTAL, 8'd0);
        read_check("t6_oob_max", 131071, 8'd0);
        vs_pulse();
        rd_addr = 17'd5;
        beat(8'h30, 8'h31);
        beat(8'h32, 8'h33);
        beat(8'hC4, 8'hC5);
        check("t6_rbw_old", rd_data, 8'd5);
        step();
        check("t6_rbw_new", rd_data, 8'hC5);
        check("t6_short_flag", err_short_line, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
